// File: rtl/multi_key_input_controller.sv
// Multi-key input controller: per-key sync/debounce, frame-gated event scan into an interrupt FIFO.
// Define KEY_RELEASE_EVENT_EN to also queue key-release events (instruction bit 8 set) after presses.
module multi_key_input_controller #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [4:0]  IRQ_OPCODE      = 5'b11111
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                frame_rt_clk,
    input  logic                interrupt_ack,
    output logic [31:0]         interrupt_instruction,
    output logic                interrupt_valid,
    output logic                fifo_full,
    output logic [7:0]          dropped_count
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = AW + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    logic [NUM_KEYS-1:0] key_s1, key_s2, deb, deb_prev;
    logic [NUM_KEYS-1:0] press_evt, rel_evt;
    logic [NUM_KEYS-1:0] pending, rel_pending, scan_press, scan_rel;
    logic [NUM_KEYS-1:0] scan_press_n, scan_rel_n;
    logic [CW-1:0]       db_cnt [NUM_KEYS];
    logic                frm_s1, frm_s2, frm_prev, frame_edge;
    state_t              state;
    logic [7:0]          prs_idx, rel_idx, sel_idx;
    logic                sel_rel, scan_done;
    logic [31:0]         push_data, head_n;
    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_ptr_n;
    logic [OW-1:0]       count, count_n;
    logic                push, pop, drop;

    // Synchronise and debounce every key; the debounced level only flips after a full stable window.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            key_s1   <= '0;
            key_s2   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int k = 0; k < int'(NUM_KEYS); k++) db_cnt[k] <= '0;
        end else begin
            key_s1   <= keys;
            key_s2   <= key_s1;
            deb_prev <= deb;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                if (key_s2[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[k]    <= ~deb[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + CW'(1);
                end
            end
        end
    end

    assign press_evt  = deb & ~deb_prev;
`ifdef KEY_RELEASE_EVENT_EN
    assign rel_evt    = ~deb & deb_prev;
`else
    assign rel_evt    = '0;
`endif
    assign frame_edge = frm_s2 & ~frm_prev;

    // Pick the lowest pending key; presses drain before releases.
    always_comb begin
        prs_idx      = '0;
        rel_idx      = '0;
        sel_idx      = '0;
        sel_rel      = 1'b0;
        scan_press_n = scan_press;
        scan_rel_n   = scan_rel;
        for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
            if (scan_press[k]) prs_idx = 8'(k);
            if (scan_rel[k])   rel_idx = 8'(k);
        end
        if (scan_press != '0) begin
            sel_idx      = prs_idx;
            scan_press_n = scan_press & (scan_press - NUM_KEYS'(1));
        end else begin
            sel_idx    = rel_idx;
            sel_rel    = 1'b1;
            scan_rel_n = scan_rel & (scan_rel - NUM_KEYS'(1));
        end
        scan_done = (scan_press_n == '0) && (scan_rel_n == '0);
        push_data = {IRQ_OPCODE, 18'b0, sel_rel, sel_idx};
    end

    // FIFO control; a pop in the same cycle makes room for a push into a full FIFO.
    always_comb begin
        pop      = interrupt_valid && interrupt_ack;
        push     = (state == SCAN) && ((count != OW'(FIFO_DEPTH)) || interrupt_ack);
        drop     = (state == SCAN) && !push;
        count_n  = count + OW'(push) - OW'(pop);
        rd_ptr_n = rd_ptr + AW'(pop);
        if (count_n == '0)
            head_n = 32'h0;
        else if (push && ((count - OW'(pop)) == '0))
            head_n = push_data;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            count                 <= '0;
            interrupt_instruction <= 32'h0;
            interrupt_valid       <= 1'b0;
            fifo_full             <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr                <= rd_ptr_n;
            count                 <= count_n;
            interrupt_instruction <= head_n;
            interrupt_valid       <= (count_n != '0);
            fifo_full             <= (count_n == OW'(FIFO_DEPTH));
        end
    end

    // Frame-gated scan FSM; events arriving during a scan wait for the next frame.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            frm_s1        <= 1'b0;
            frm_s2        <= 1'b0;
            frm_prev      <= 1'b0;
            pending       <= '0;
            rel_pending   <= '0;
            scan_press    <= '0;
            scan_rel      <= '0;
            dropped_count <= '0;
        end else begin
            frm_s1   <= frame_rt_clk;
            frm_s2   <= frm_s1;
            frm_prev <= frm_s2;
            case (state)
                IDLE: begin
                    if (frame_edge && ((pending != '0) || (rel_pending != '0))) begin
                        scan_press  <= pending;
                        scan_rel    <= rel_pending;
                        pending     <= press_evt;
                        rel_pending <= rel_evt;
                        state       <= SCAN;
                    end else begin
                        pending     <= pending | press_evt;
                        rel_pending <= rel_pending | rel_evt;
                    end
                end
                SCAN: begin
                    pending     <= pending | press_evt;
                    rel_pending <= rel_pending | rel_evt;
                    scan_press  <= scan_press_n;
                    scan_rel    <= scan_rel_n;
                    if (drop && (dropped_count != 8'hFF))
                        dropped_count <= dropped_count + 8'd1;
                    if (scan_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_key_input_controller.md
Name: multi_key_input_controller

Overview:
- Parametrised successor to the single-jump-key input controller. It serves NUM_KEYS keys, each with synchronisation and debounce.
- Key-press events accumulate between game frames. On each frame_rt_clk rising edge they are queued, lowest key index first, into an interrupt-instruction FIFO.
- The CPU interrupt path drains the FIFO through a valid/ack handshake.
- Sits between the board key inputs and the processor interrupt injection logic. It runs on sysclk, with frame_rt_clk coming from the frame-rate clock_divider.

Parameters:
- NUM_KEYS, 4, number of key inputs (1..16).
- DEBOUNCE_CYCLES, 16, consecutive stable sysclk cycles required before a key's debounced state changes (>=1).
- FIFO_DEPTH, 4, instruction FIFO entries (power of two, >=2).
- IRQ_OPCODE, 5'b11111, opcode placed in instruction bits [31:27].

Ports:
- sysclk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- keys  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
- frame_rt_clk  input  1  divided frame-rate clock, a level signal; its rising edge marks a frame boundary.
- interrupt_ack  input  1  consumer accepts the head entry when high with interrupt_valid.
- interrupt_instruction  output  32  head FIFO entry; 32'h0 (nop) when FIFO empty.
- interrupt_valid  output  1  FIFO non-empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- dropped_count  output  8  saturating count of events discarded because the FIFO was full.

Behaviour:
- Reset (async, high) clears:
  - sync flops, debounced states, debounce counters, pending mask, scan mask, FIFO pointers, frame edge register, dropped_count.
  - Outputs during and after reset: interrupt_instruction=0, interrupt_valid=0, fifo_full=0, dropped_count=0.
- Per key, input conditioning:
  - 2-flop synchroniser.
  - Counter increments while the synced level differs from the debounced state and resets to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
  - A debounced 0->1 transition is a press event and sets pending[k] the following cycle.
  - Latency from a stable pin change to pending set: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Frame edge detection:
  - frame_rt_clk passes through a 2-flop synchroniser plus a previous-value register.
  - frame_edge = synced & ~prev, a one-cycle pulse.
- FSM IDLE:
  - On frame_edge with pending != 0: scan <= pending, pending cleared except bits set by press events in that same cycle, which stay set. Go to SCAN.
  - On frame_edge with pending == 0: no action.
- FSM SCAN, one key per cycle:
  - Select the lowest set bit k of scan and clear it.
  - If the FIFO is not full, push {IRQ_OPCODE, 19'b0, 8'(k)}.
  - Else drop the event and increment dropped_count, saturating at 255.
  - A pop in the same cycle frees a slot: push allowed when full && interrupt_ack.
  - Go to IDLE when scan becomes 0 after this cycle.
  - frame_edge during SCAN is ignored; pending keeps accumulating for the next frame.
- Repeat presses: a key pressed more than once in a frame yields a single event.
- FIFO:
  - Pop when interrupt_valid && interrupt_ack.
  - Simultaneous push and pop keep the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ack while empty is ignored.
  - Head data is registered: a new entry is visible the cycle after its push.
- Reset asserted mid-SCAN aborts the scan immediately. Events still in scan or pending are lost.

Optional Feature:
- Macro KEY_RELEASE_EVENT_EN.
- When defined:
  - A debounced 1->0 transition sets a second mask, release_pending[k].
  - At a frame edge both masks are snapshotted. Scan order is all press events in ascending k, then all release events in ascending k.
  - Release instructions set bit 8: {IRQ_OPCODE, 18'b0, 1'b1, 8'(k)}.
- When undefined: releases generate nothing, and bit 8 is always 0.

Test Plan:
- keys[2] held high 40 cycles, then frame edge -> interrupt_valid rises; interrupt_instruction = 32'hF8000002; ack -> valid drops to 0.
- keys[1] toggled every 5 cycles for 60 cycles (DEBOUNCE_CYCLES=16), then frame edge -> no event; interrupt_valid stays 0.
- keys[3] and keys[0] pressed in the same frame -> entries pop in order 32'hF8000000 then 32'hF8000003.
- FIFO_DEPTH=4, no ack; press all 4 keys and frame edge, then key 0 again and frame edge -> fifo_full=1, dropped_count=1, head = 32'hF8000000.
- Key 1 pressed 3 times within one frame -> exactly one 32'hF8000001 entry.
- Reset asserted during SCAN with 3 keys pending -> all outputs return to 0 within the reset cycle; no entries remain after release.
